main_fsm: RTL and testbench

- Multicycle control unit that sits directly upstream of the conditional-execution stage. It decodes the current instruction's Op, Funct and Rd fields.
- Each instruction is sequenced through FETCH/DECODE/execute/writeback states.
- Produces the unconditioned write requests PCS, RegW, MemW and FlagW that condlogic later gates with CondEx.
- Also produces every datapath mux select, ALUControl, IRWrite and NextPC.

---
 rtl/main_fsm_pkg.sv | 35 +++
 rtl/main_fsm_alu_dec.sv | 53 +++++
 rtl/main_fsm.sv | 177 +++++++++++++++++
 tb/tb_main_fsm.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared definitions for the multicycle control unit.
//   - state_t     : FSM state codes (codes 10..15 are illegal)
//   - OP_*        : instruction class codes carried in Instr[27:26]
//   - CMD_*       : data-processing command codes carried in Funct[4:1]
//   - ALU_*       : ALUControl encodings driven to the datapath ALU
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/main_fsm_alu_dec.sv
// alu_dec: combinational ALU decoder.
// Ports:
//   Funct      in  [4:0] Instr[24:20]; [4:1] = cmd, [0] = S
//   ALUOp      in        asserted by the FSM in the execute states
//   ALUControl out [1:0] 00 ADD, 01 SUB, 10 AND, 11 ORR
//   FlagW      out [1:0] [1] = N,Z write request; [0] = C,V write request
module alu_dec
  import main_fsm_pkg::*;
(
  input  logic [4:0] Funct,
  input  logic       ALUOp,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       set_flags;

  assign cmd       = Funct[4:1];
  assign set_flags = Funct[0];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ALUOp) begin
      // Unsupported commands fall back to ADD and never touch the flags.
      // C,V are only meaningful for arithmetic, so logic ops update N,Z only.
      unique case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {set_flags, set_flags};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {set_flags, set_flags};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {set_flags, 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {set_flags, 1'b0};
        end
        default: begin
          ALUControl = ALU_ADD;
          FlagW      = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle control unit sequencing each instruction through
// FETCH / DECODE / execute / writeback. Produces the unconditioned write
// requests (PCS, RegW, MemW, FlagW) later gated by the condition logic,
// plus every datapath mux select, ALUControl, IRWrite and NextPC.
// Ports:
//   clk        in              rising-edge clock
//   reset      in              asynchronous active-low reset
//   Op         in  [1:0]       Instr[27:26] instruction class
//   Funct      in  [5:0]       Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   Rd         in  [3:0]       Instr[15:12] destination register
//   IRWrite    out             instruction register load enable
//   NextPC     out             PC load enable for the fetch increment
//   AdrSrc     out             memory address: 0 PC, 1 ALU result
//   ALUSrcA    out             ALU A: 0 register, 1 PC
//   ALUSrcB    out [1:0]       ALU B: 00 register, 01 immediate, 10 const 4
//   ResultSrc  out [1:0]       result: 00 ALUOut, 01 read data, 10 ALU result
//   ImmSrc     out [1:0]       immediate format (equals Op)
//   RegSrc     out [1:0]       register-file read address selects
//   ALUControl out [1:0]       ALU operation
//   FlagW      out [1:0]       flag write request
//   PCS        out             PC-from-result request
//   RegW       out             register write request
//   MemW       out             memory write request
//   state      out [STATE_W-1:0] current state code, for debug
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         FlagW,
  output logic               PCS,
  output logic               RegW,
  output logic               MemW,
  output logic [STATE_W-1:0] state
);

  state_t     state_reg;
  state_t     state_next;

  logic       irwrite_raw;
  logic       nextpc_raw;
  logic       regw_raw;
  logic       memw_raw;
  logic       branch;
  logic       alu_op;
  logic [1:0] flagw_raw;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = S_FETCH;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore output decode; illegal codes fall into the all-zero default.
  always_comb begin
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch      = 1'b0;
    alu_op      = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    case (state_reg)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        nextpc_raw  = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB     = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc      = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        regw_raw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc      = 1'b1;
        memw_raw    = 1'b1;
      end
      S_EXECR: begin
        alu_op      = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB     = 2'b01;
        alu_op      = 1'b1;
      end
      S_ALUWB: begin
        regw_raw    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB     = 2'b01;
        ResultSrc   = 2'b10;
        branch      = 1'b1;
      end
      default: begin
        irwrite_raw = 1'b0;
      end
    endcase
  end

  alu_dec u_alu_dec (
    .Funct      (Funct[4:0]),
    .ALUOp      (alu_op),
    .ALUControl (ALUControl),
    .FlagW      (flagw_raw)
  );

  // The state register already reads FETCH while reset is low, but FETCH
  // asserts IRWrite/NextPC, so every enable is also masked by reset itself.
  assign IRWrite = irwrite_raw & reset;
  assign NextPC  = nextpc_raw & reset;
  assign RegW    = regw_raw & reset;
  assign MemW    = memw_raw & reset;
  assign FlagW   = flagw_raw & {2{reset}};
  // Writing R15 is a jump, so PCS follows Rd combinationally.
  assign PCS     = (branch | (regw_raw & (Rd == 4'hF))) & reset;

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == OP_MEM), (Op == OP_BR)};
  assign state   = STATE_W'(state_reg);

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized self-checking bench for main_fsm. An instruction-
// level model predicts, for each instruction, the list of cycles it occupies
// and the outputs seen in each; a compare process checks one cycle per
// falling clock edge.
module tb_main_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       npc;
    logic       adr;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic [1:0] aluc;
    logic [1:0] flw;
    logic       pcs;
    logic       regw;
    logic       memw;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  obs_t act;

  always #5 clk = ~clk;

  main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .state(state)
  );

  assign act = '{st: state, irw: IRWrite, npc: NextPC, adr: AdrSrc,
                 asa: ALUSrcA, asb: ALUSrcB, res: ResultSrc, imm: ImmSrc,
                 rsrc: RegSrc, aluc: ALUControl, flw: FlagW, pcs: PCS,
                 regw: RegW, memw: MemW};

  // ---------------- instruction-level reference model ----------------
  function automatic int model_len(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;   // LDR 5, STR 4
      2'b00:   return 4;              // data processing
      2'b10:   return 3;              // branch
      default: return 2;              // undefined
    endcase
  endfunction

  function automatic obs_t base_obs(input logic [1:0] op);
    obs_t o;
    o = '0;
    o.imm  = op;
    o.rsrc = {op == 2'b01, op == 2'b10};
    return o;
  endfunction

  // What the outputs must be in cycle k (0 = fetch) of instruction op/f/rd.
  function automatic obs_t model_cycle(input logic [1:0] op, input logic [5:0] f,
                                       input logic [3:0] rd, input int k);
    obs_t o;
    logic s;
    o = base_obs(op);
    s = f[0];
    if (k == 0) begin
      o.st = 4'd0; o.irw = 1'b1; o.npc = 1'b1; o.asa = 1'b1; o.asb = 2'd2; o.res = 2'd2;
    end else if (k == 1) begin
      o.st = 4'd1; o.asa = 1'b1; o.asb = 2'd2; o.res = 2'd2;
    end else if (op == 2'b01) begin
      if (k == 2) begin
        o.st = 4'd2; o.asb = 2'd1;
      end else if (f[0] && k == 3) begin
        o.st = 4'd3; o.adr = 1'b1;
      end else if (f[0]) begin
        o.st = 4'd4; o.res = 2'd1; o.regw = 1'b1; o.pcs = (rd == 4'd15);
      end else begin
        o.st = 4'd5; o.adr = 1'b1; o.memw = 1'b1;
      end
    end else if (op == 2'b00) begin
      if (k == 2) begin
        o.st  = f[5] ? 4'd7 : 4'd6;
        o.asb = f[5] ? 2'd1 : 2'd0;
        case (f[4:1])
          4'd4:    begin o.aluc = 2'd0; o.flw = {s, s};    end
          4'd2:    begin o.aluc = 2'd1; o.flw = {s, s};    end
          4'd0:    begin o.aluc = 2'd2; o.flw = {s, 1'b0}; end
          4'd12:   begin o.aluc = 2'd3; o.flw = {s, 1'b0}; end
          default: begin o.aluc = 2'd0; o.flw = 2'd0;      end
        endcase
      end else begin
        o.st = 4'd8; o.regw = 1'b1; o.pcs = (rd == 4'd15);
      end
    end else begin
      o.st = 4'd9; o.asb = 2'd1; o.res = 2'd2; o.pcs = 1'b1;
    end
    return o;
  endfunction

  // While reset is low: FETCH code, FETCH mux selects, no enables.
  function automatic obs_t reset_obs(input logic [1:0] op);
    obs_t o;
    o = base_obs(op);
    o.asa = 1'b1; o.asb = 2'd2; o.res = 2'd2;
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got %h (state %0d) expected %h (state %0d)",
               name, $time, got, got.st, want, want.st);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_obs("cycle", act, e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(reset_obs(Op));
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input string tag);
    int n;
    Op = op; Funct = f; Rd = rd;
    n = model_len(op, f);
    $display("instr %s op=%b funct=%b rd=%0d cycles=%0d", tag, op, f, rd, n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_cycle(op, f, rd, k));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    obs_t o;
    logic [1:0] rop;
    logic [5:0] rf;
    logic [3:0] rrd;
    logic [3:0] cmds [4];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;

    // Hand-computed expectations pinning the model
    check_val("pin_ldr_len", model_len(2'b01, 6'b011001), 5);
    check_val("pin_str_len", model_len(2'b01, 6'b011000), 4);
    check_val("pin_b_len", model_len(2'b10, 6'b000000), 3);
    o = model_cycle(2'b00, 6'b001001, 4'd2, 2);
    check_val("pin_adds_flagw", int'(o.flw), 3);
    check_val("pin_adds_state", int'(o.st), 6);
    o = model_cycle(2'b00, 6'b111001, 4'd2, 2);
    check_val("pin_orrs_aluc", int'(o.aluc), 3);
    check_val("pin_orrs_flagw", int'(o.flw), 2);
    o = model_cycle(2'b01, 6'b011001, 4'd3, 4);
    check_val("pin_ldr_wb_res", int'(o.res), 1);

    @(posedge clk); #1;
    run_reset(3);

    // Directed instructions
    run_instr(2'b01, 6'b011001, 4'd3,  "LDR");
    run_instr(2'b01, 6'b011000, 4'd3,  "STR");
    run_instr(2'b00, 6'b001001, 4'd2,  "ADDS_reg");
    run_instr(2'b00, 6'b111001, 4'd2,  "ORRS_imm");
    run_instr(2'b00, 6'b001000, 4'd15, "ADD_pc");
    run_instr(2'b10, 6'b000000, 4'd0,  "B");
    run_instr(2'b11, 6'b000000, 4'd15, "UNDEF");
    run_instr(2'b01, 6'b011001, 4'd15, "LDR_pc");

    // Reset pulled low in the middle of MEMWR
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd1;
    $display("instr STR_abort op=01 funct=011000 rd=1");
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(model_cycle(Op, Funct, Rd, k));
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check_obs("abort_immediate", act, reset_obs(Op));
    @(posedge clk); #1;
    run_reset(2);
    run_instr(2'b00, 6'b000101, 4'd4, "SUBS_after_abort");

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom);
      if ($urandom_range(0, 3) != 0) rf[4:1] = cmds[$urandom_range(0, 3)];
      rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(rop, rf, rrd, "rand");
    end

    @(negedge clk); #1;
    check_val("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
